sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Shares one single-ported synchronous SRAM between the CPU instruction-fetch port and data port. Both ports use the sram-like req/addr_ok/data_ok handshake. Sits between the mips core and the external SRAM, so the core can run against a unified memory. Data has fixed priority, with a starvation override for fetch; byte-lane write enables are generated from size and address.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width (fixed 4 byte lanes)
STARVE_LIMIT, 4, consecutive lost conflicts before fetch wins; 0 = never override (pure data priority)

Ports:
clk  in  1  core clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
inst_req  in  1  fetch request (read only)
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  DATA_W  fetch read data
data_req  in  1  data request
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 byte, 1 half, 2 word, 3 treated as word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data, low-aligned
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  load data valid / store complete this cycle
data_rdata  out  DATA_W  load data, full word
sram_en  out  1  SRAM enable
sram_wen  out  4  SRAM byte write enables
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid one cycle after the enabled edge

Behaviour:
- Grant is combinational. Cycle N: at most one requester gets addr_ok=1; sram_en=1 and sram_addr/wen/wdata are driven from that requester.
- Cycle N+1: the granted port's data_ok=1, and its rdata = sram_rdata. Stores also return data_ok at N+1, with rdata undefined.
- Back-to-back: a new grant may occur in the same cycle as the previous data_ok. Throughput is 1 access/cycle.
- Requesters must accept data_ok; there is no back-pressure. req/addr/wr/size/wdata must hold stable until addr_ok.
- Owner register: OWN_NONE/OWN_INST/OWN_DATA. It is set to the grant at each edge, or OWN_NONE if nothing is granted. data_ok outputs decode the owner register.
- Arbitration:
  - Only one request -> it wins.
  - Both requesting -> data wins, unless starve_cnt == STARVE_LIMIT (with STARVE_LIMIT != 0), in which case inst wins.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each cycle where both request and data wins.
  - Clears on an inst grant or when inst_req=0.
- Write enables:
  - Load: wen=0000.
  - Byte: wen = 1 << addr[1:0].
  - Half: wen = addr[1] ? 1100 : 0011.
  - Word and size 3: wen = 1111.
- Write data: byte replicates data_wdata[7:0] ×4; half replicates [15:0] ×2; word passes through.
- Misalignment is not checked; the core raises AdEL/AdES before issuing.
- sram_addr passes the address through unmodified. When there is no grant: sram_en=0, wen=0000, addr/wdata=0.
- Reset values: addr_ok/data_ok outputs 0, owner OWN_NONE, starve_cnt 0, rdata outputs 0.
- Reset asserted mid-access: the outstanding response is dropped and no data_ok follows.
- The datapath is combinational from the inputs, so the core must not combinationally loop addr_ok back into req.

Decomposition:
- Package sram_arb_pkg holds:
  - owner_t enum (OWN_NONE, OWN_INST, OWN_DATA)
  - size constants SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2
  - WEN_NONE/WEN_ALL constants
- Sub-module sram_wen_gen: combinational. Takes (wr, size, addr[1:0], wdata) and produces (wen, wdata_rep). It is instantiated once on the data path.

Test Plan:
- inst_req only, addr 0xBFC00000 for 3 cycles, SRAM returns 0x11,0x22,0x33 -> inst_addr_ok=1 each cycle; inst_data_ok=1 in cycles 2..4 with those rdata values; data_* outputs stay 0.
- Simultaneous inst_req and data_req load 0x80001000 -> data granted first; the fetch is granted the next cycle; data_data_ok then inst_data_ok on consecutive cycles.
- Store byte, addr 0x...03, wdata 0xAB -> sram_wen=1000, sram_wdata=0xABABABAB. Store half at 0x...02 -> wen=1100. Store word -> 1111. data_data_ok follows one cycle later.
- STARVE_LIMIT=4, both requesting continuously -> data granted 4 cycles, inst granted on cycle 5, then the pattern repeats. With STARVE_LIMIT=0, inst is never granted while data_req=1.
- resetn pulsed low asynchronously (mid-clock) in the cycle after a grant -> no data_ok, all outputs 0 immediately. After release, the first request is served normally.
- data_size=3 store -> behaves exactly as a word store (wen=1111, wdata unchanged).

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_ALL  = 4'b1111;

endpackage

// File: rtl/sram_wen_gen.sv
// Byte-lane write enables and lane-replicated store data for the data port.
module sram_wen_gen
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [3:0]        wen,
    output logic [DATA_W-1:0] wdata_rep
);

    localparam int LANE_W = DATA_W / 4;

    // Size 3 falls into the default arm and behaves as a full word.
    always_comb begin
        wen       = WEN_NONE;
        wdata_rep = wdata;
        case (size)
            SIZE_BYTE: begin
                wdata_rep = {4{wdata[LANE_W-1:0]}};
                if (wr) wen = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                wdata_rep = {2{wdata[2*LANE_W-1:0]}};
                if (wr) wen = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                if (wr) wen = WEN_ALL;
            end
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous single-port SRAM between the fetch and data ports,
// data first, with a starvation override that lets a waiting fetch through.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    owner_t             owner;
    owner_t             grant;
    logic               inst_wins;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_nxt;
    logic [3:0]         data_wen;
    logic [DATA_W-1:0]  data_wdata_rep;

    sram_wen_gen #(
        .DATA_W (DATA_W)
    ) u_wen_gen (
        .wr        (data_wr),
        .size      (data_size),
        .addr_lo   (data_addr[1:0]),
        .wdata     (data_wdata),
        .wen       (data_wen),
        .wdata_rep (data_wdata_rep)
    );

    // Grant is gated by resetn so an asserted reset silences the SRAM at once.
    always_comb begin
        grant     = OWN_NONE;
        inst_wins = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
        if (!resetn) begin
            grant = OWN_NONE;
        end else if (inst_req && data_req) begin
            grant = inst_wins ? OWN_INST : OWN_DATA;
        end else if (data_req) begin
            grant = OWN_DATA;
        end else if (inst_req) begin
            grant = OWN_INST;
        end
    end

    always_comb begin
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        sram_en      = 1'b0;
        sram_wen     = WEN_NONE;
        sram_addr    = '0;
        sram_wdata   = '0;
        case (grant)
            OWN_INST: begin
                inst_addr_ok = 1'b1;
                sram_en      = 1'b1;
                sram_addr    = inst_addr;
            end
            OWN_DATA: begin
                data_addr_ok = 1'b1;
                sram_en      = 1'b1;
                sram_wen     = data_wen;
                sram_addr    = data_addr;
                sram_wdata   = data_wdata_rep;
            end
            default: ;
        endcase
    end

    // Counts conflicts the fetch lost in a row; saturates at the limit.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!inst_req || grant == OWN_INST) begin
            starve_nxt = '0;
        end else if (grant == OWN_DATA && starve_cnt != STARVE_MAX) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            owner      <= grant;
            starve_cnt <= starve_nxt;
        end
    end

    assign inst_data_ok = (owner == OWN_INST);
    assign data_data_ok = (owner == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
    assign data_rdata   = data_data_ok ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (starve limit 4 and 0) checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_sram_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] sram_rdata;

    logic        inst_addr_ok_a, inst_data_ok_a, data_addr_ok_a, data_data_ok_a, sram_en_a;
    logic [31:0] inst_rdata_a, data_rdata_a, sram_addr_a, sram_wdata_a;
    logic [3:0]  sram_wen_a;
    logic        inst_addr_ok_z, inst_data_ok_z, data_addr_ok_z, data_data_ok_z, sram_en_z;
    logic [31:0] inst_rdata_z, data_rdata_z, sram_addr_z, sram_wdata_z;
    logic [3:0]  sram_wen_z;

    int checks = 0;
    int errors = 0;

    int lim      [2] = '{4, 0};
    int m_owner  [2];
    int m_starve [2];
    bit m_store  [2];

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok_a), .inst_data_ok(inst_data_ok_a), .inst_rdata(inst_rdata_a),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok_a), .data_data_ok(data_data_ok_a), .data_rdata(data_rdata_a),
        .sram_en(sram_en_a), .sram_wen(sram_wen_a), .sram_addr(sram_addr_a),
        .sram_wdata(sram_wdata_a), .sram_rdata(sram_rdata)
    );

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) dut_z (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok_z), .inst_data_ok(inst_data_ok_z), .inst_rdata(inst_rdata_z),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok_z), .data_data_ok(data_data_ok_z), .data_rdata(data_rdata_z),
        .sram_en(sram_en_z), .sram_wen(sram_wen_z), .sram_addr(sram_addr_z),
        .sram_wdata(sram_wdata_z), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model grant: 0 none, 1 fetch, 2 data.
    function automatic int model_grant(input int k);
        if (!resetn) return 0;
        if (inst_req && data_req) return (lim[k] != 0 && m_starve[k] == lim[k]) ? 1 : 2;
        if (data_req) return 2;
        if (inst_req) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] model_wen();
        int sz;
        sz = (data_size == 2'd3) ? 2 : int'(data_size);
        if (!data_wr) return 4'd0;
        if (sz == 0) return 4'(1 << data_addr[1:0]);
        if (sz == 1) return 4'(3 << (data_addr[1:0] & 2'd2));
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata();
        if (data_size == 2'd0) return 32'(data_wdata[7:0]) * 32'h0101_0101;
        if (data_size == 2'd1) return 32'(data_wdata[15:0]) * 32'h0001_0001;
        return data_wdata;
    endfunction

    always @(posedge clk or negedge resetn) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                m_owner[k]  = 0;
                m_starve[k] = 0;
                m_store[k]  = 1'b0;
            end else begin
                int g;
                g = model_grant(k);
                m_store[k] = (g == 2) && data_wr;
                if (!inst_req || g == 1) m_starve[k] = 0;
                else if (g == 2 && m_starve[k] < lim[k]) m_starve[k] = m_starve[k] + 1;
                m_owner[k] = g;
            end
        end
    end

    task automatic compare_dut(input int k, input logic iaok, input logic daok,
                               input logic idok, input logic ddok,
                               input logic [31:0] ird, input logic [31:0] drd,
                               input logic en, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] wdata);
        int g;
        g = model_grant(k);
        check_output($sformatf("dut%0d inst_addr_ok", k), iaok, g == 1);
        check_output($sformatf("dut%0d data_addr_ok", k), daok, g == 2);
        check_output($sformatf("dut%0d inst_data_ok", k), idok, m_owner[k] == 1);
        check_output($sformatf("dut%0d data_data_ok", k), ddok, m_owner[k] == 2);
        check_output($sformatf("dut%0d inst_rdata", k), ird, (m_owner[k] == 1) ? sram_rdata : 32'd0);
        if (m_owner[k] != 2)
            check_output($sformatf("dut%0d data_rdata idle", k), drd, 32'd0);
        else if (!m_store[k])
            check_output($sformatf("dut%0d data_rdata", k), drd, sram_rdata);
        check_output($sformatf("dut%0d sram_en", k), en, g != 0);
        check_output($sformatf("dut%0d sram_wen", k), wen, (g == 2) ? model_wen() : 4'd0);
        check_output($sformatf("dut%0d sram_addr", k), addr,
                     (g == 2) ? data_addr : (g == 1) ? inst_addr : 32'd0);
        if (g == 0)
            check_output($sformatf("dut%0d sram_wdata idle", k), wdata, 32'd0);
        else if (g == 2 && data_wr)
            check_output($sformatf("dut%0d sram_wdata", k), wdata, model_wdata());
    endtask

    always @(negedge clk) begin
        compare_dut(0, inst_addr_ok_a, data_addr_ok_a, inst_data_ok_a, data_data_ok_a,
                    inst_rdata_a, data_rdata_a, sram_en_a, sram_wen_a, sram_addr_a, sram_wdata_a);
        compare_dut(1, inst_addr_ok_z, data_addr_ok_z, inst_data_ok_z, data_data_ok_z,
                    inst_rdata_z, data_rdata_z, sram_en_z, sram_wen_z, sram_addr_z, sram_wdata_z);
    end

    task automatic apply_stimulus(input logic ir, input logic [31:0] ia,
                                  input logic dr, input logic dw, input logic [1:0] ds,
                                  input logic [31:0] da, input logic [31:0] dd,
                                  input logic [31:0] rd);
        @(posedge clk);
        #1;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_size  = ds;
        data_addr  = da;
        data_wdata = dd;
        sram_rdata = rd;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
        data_size = '0; data_addr = '0; data_wdata = '0; sram_rdata = '0;
        #2;
        check_output("reset inst_data_ok", inst_data_ok_a, 1'b0);
        check_output("reset data_data_ok", data_data_ok_a, 1'b0);
        check_output("reset sram_en", sram_en_a, 1'b0);
        check_output("reset data_rdata", data_rdata_a, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Fetch-only stream
        apply_stimulus(1, 32'hBFC0_0000, 0, 0, 2, 0, 0, 32'h0);
        check_output("fetch1 addr_ok", inst_addr_ok_a, 1'b1);
        apply_stimulus(1, 32'hBFC0_0000, 0, 0, 2, 0, 0, 32'h11);
        check_output("fetch2 rdata", inst_rdata_a, 32'h11);
        apply_stimulus(1, 32'hBFC0_0000, 0, 0, 2, 0, 0, 32'h22);
        check_output("fetch3 rdata", inst_rdata_a, 32'h22);
        apply_stimulus(0, 0, 0, 0, 2, 0, 0, 32'h33);
        check_output("fetch4 data_ok", inst_data_ok_a, 1'b1);
        check_output("fetch4 rdata", inst_rdata_a, 32'h33);
        check_output("fetch4 data port quiet", data_data_ok_a, 1'b0);

        // Conflict: data first, fetch next
        apply_stimulus(1, 32'hBFC0_0004, 1, 0, 2, 32'h8000_1000, 0, 0);
        check_output("conflict data wins", data_addr_ok_a, 1'b1);
        check_output("conflict inst waits", inst_addr_ok_a, 1'b0);
        apply_stimulus(1, 32'hBFC0_0004, 0, 0, 2, 0, 0, 32'hD0);
        check_output("conflict inst granted", inst_addr_ok_a, 1'b1);
        check_output("conflict load rdata", data_rdata_a, 32'hD0);
        apply_stimulus(0, 0, 0, 0, 2, 0, 0, 32'h10);
        check_output("conflict fetch rdata", inst_rdata_a, 32'h10);

        // Stores of each size
        apply_stimulus(0, 0, 1, 1, 0, 32'h8000_0003, 32'h0000_00AB, 0);
        check_output("sb wen", sram_wen_a, 4'b1000);
        check_output("sb wdata", sram_wdata_a, 32'hABAB_ABAB);
        apply_stimulus(0, 0, 1, 1, 0, 32'h8000_0001, 32'h0000_0055, 0);
        check_output("sb1 wen", sram_wen_a, 4'b0010);
        check_output("sb data_ok", data_data_ok_a, 1'b1);
        apply_stimulus(0, 0, 1, 1, 1, 32'h8000_0002, 32'h0000_1234, 0);
        check_output("sh wen", sram_wen_a, 4'b1100);
        check_output("sh wdata", sram_wdata_a, 32'h1234_1234);
        apply_stimulus(0, 0, 1, 1, 2, 32'h8000_0000, 32'hDEAD_BEEF, 0);
        check_output("sw wen", sram_wen_a, 4'b1111);
        apply_stimulus(0, 0, 1, 1, 3, 32'h8000_0004, 32'hCAFE_F00D, 0);
        check_output("size3 wen", sram_wen_a, 4'b1111);
        check_output("size3 wdata", sram_wdata_a, 32'hCAFE_F00D);
        apply_stimulus(0, 0, 1, 0, 2, 32'h8000_0008, 0, 0);
        check_output("load wen", sram_wen_a, 4'b0000);
        apply_stimulus(0, 0, 0, 0, 2, 0, 0, 32'h99);
        check_output("load data_ok", data_data_ok_a, 1'b1);

        // Continuous conflict: limit 4 lets fetch in every fifth cycle
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 32'hBFC0_0100, 1, 0, 2, 32'h8000_3000, 0, 32'(i));
            check_output($sformatf("starve4 cycle %0d", i), inst_addr_ok_a, (i == 4 || i == 9));
            check_output($sformatf("starve0 cycle %0d", i), inst_addr_ok_z, 1'b0);
        end
        apply_stimulus(0, 0, 0, 0, 2, 0, 0, 0);

        // Asynchronous reset in the cycle after a grant
        apply_stimulus(0, 0, 1, 0, 2, 32'h8000_2000, 0, 0);
        check_output("pre-reset grant", data_addr_ok_a, 1'b1);
        @(posedge clk);
        #1;
        data_addr  = 32'h8000_2004;
        sram_rdata = 32'h77;
        #1 resetn = 1'b0;
        #1;
        check_output("in-reset data_ok", data_data_ok_a, 1'b0);
        check_output("in-reset data_rdata", data_rdata_a, 32'd0);
        check_output("in-reset addr_ok", data_addr_ok_a, 1'b0);
        check_output("in-reset sram_en", sram_en_a, 1'b0);
        check_output("in-reset sram_addr", sram_addr_a, 32'd0);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_output("post-reset no data_ok", data_data_ok_a, 1'b0);
        check_output("post-reset grant", data_addr_ok_a, 1'b1);
        apply_stimulus(0, 0, 0, 0, 2, 0, 0, 32'h55);
        check_output("post-reset rdata", data_rdata_a, 32'h55);
        apply_stimulus(0, 0, 0, 0, 2, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
